// File: rtl/prim_pad_wrapper_pkg.sv
// Shared pad-wrapper types and helpers.
// - pad_pok_t  : one bank power-ok vector at the default width; modules that
//                change PokW declare their own logic [PokW-1:0] view.
// - bank_idx_t : widest bank index a pad may carry. Each module narrows it to
//                its own BankIdxW.
// - bank_idx_w : index width for n banks. It is never below 1, so a
//                single-bank build still has a legal index field.
package prim_pad_wrapper_pkg;

  localparam int unsigned PokWDefault = 8;
  localparam int unsigned BankIdxWMax = 8;

  typedef logic [PokWDefault-1:0] pad_pok_t;
  typedef logic [BankIdxWMax-1:0] bank_idx_t;

  function automatic int unsigned bank_idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_pok_monitor_if.sv
// Signal bundle of pad_pok_monitor: the bank power-ok inputs, the interrupt
// controls, and the debounced / status outputs.
// - master : the side that drives pok_i, irq_en_i and irq_clr_i (the
//            environment).
// - slave  : the monitor side.
interface pad_pok_monitor_if #(
  parameter int unsigned NumBanks = 4,
  parameter int unsigned NumPads  = 8,
  parameter int unsigned PokW     = 8
);
  logic [NumBanks-1:0][PokW-1:0] pok_i;
  logic [NumBanks-1:0]           irq_en_i;
  logic [NumBanks-1:0]           irq_clr_i;
  logic [NumPads-1:0][PokW-1:0]  pad_pok_o;
  logic [NumBanks-1:0]           bank_ok_o;
  logic [NumBanks-1:0]           change_o;
  logic [NumBanks-1:0]           irq_status_o;
  logic                          irq_o;

  modport master (
    output pok_i, irq_en_i, irq_clr_i,
    input  pad_pok_o, bank_ok_o, change_o, irq_status_o, irq_o
  );

  modport slave (
    input  pok_i, irq_en_i, irq_clr_i,
    output pad_pok_o, bank_ok_o, change_o, irq_status_o, irq_o
  );
endinterface

// File: rtl/pad_pok_debounce.sv
// One bank: a two-flop synchronizer followed by a debounce stage.
// Ports:
// - clk, rst_ni : clock and asynchronous active-low reset.
// - pok         : raw bank vector, asynchronous to clk.
// - st          : accepted (stable) bank vector.
// - change      : one-cycle pulse on the cycle after st is updated.
module pad_pok_debounce #(
  parameter int unsigned PokW           = 8,
  parameter int unsigned DebounceCycles = 4
) (
  input  logic            clk,
  input  logic            rst_ni,
  input  logic [PokW-1:0] pok,
  output logic [PokW-1:0] st,
  output logic            change
);

  localparam int unsigned CntW = $clog2(DebounceCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

  if (DebounceCycles < 1 || DebounceCycles > 255) begin : g_bad_cycles
    $error("pad_pok_debounce: DebounceCycles must be in 1..255");
  end

  logic [PokW-1:0] meta, s, s_prev;
  logic [CntW-1:0] cnt, cnt_eff;

  // When s changes, the new value counts as its own first cycle.
  // The count therefore restarts at zero in that same cycle. As a result a
  // steady change commits DebounceCycles edges after it leaves the
  // synchronizer, and DebounceCycles == 1 commits on the first differing cycle.
  assign cnt_eff = (s != s_prev) ? '0 : cnt;

  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      meta   <= '0;
      s      <= '0;
      s_prev <= '0;
      st     <= '0;
      cnt    <= '0;
      change <= 1'b0;
    end else begin
      meta   <= pok;
      s      <= meta;
      s_prev <= s;
      change <= 1'b0;
      if (s == st) begin
        cnt <= '0;
      end else if (cnt_eff == CntLast) begin
        st     <= s;
        cnt    <= '0;
        change <= 1'b1;
      end else begin
        cnt <= cnt_eff + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pad_pok_monitor.sv
// Pad power-ok monitor. Each bank's raw power-ok vector is synchronized and
// debounced, then routed to pads according to PadBank. The block also keeps
// sticky per-bank change status with an interrupt output.
// Ports:
// - clk, rst_ni  : clock and asynchronous active-low reset.
// - pok_i        : raw per-bank vectors, asynchronous to clk.
// - irq_en_i     : per-bank interrupt enables.
// - irq_clr_i    : per-bank status clear pulses.
// - pad_pok_o    : per-pad debounced vector of the bank that drives the pad.
// - bank_ok_o    : per-bank "all bits good".
// - change_o     : per-bank one-cycle pulse on each accepted change.
// - irq_status_o : sticky per-bank change status.
// - irq_o        : OR over banks of (status AND enable).
module pad_pok_monitor
  import prim_pad_wrapper_pkg::*;
#(
  parameter int unsigned NumBanks       = 4,
  parameter int unsigned NumPads        = 8,
  parameter int unsigned PokW           = 8,
  parameter int unsigned DebounceCycles = 4,
  localparam int unsigned BankIdxW      = bank_idx_w(NumBanks),
  parameter logic [NumPads-1:0][BankIdxW-1:0] PadBank = '0
) (
  input  logic                          clk,
  input  logic                          rst_ni,
  input  logic [NumBanks-1:0][PokW-1:0] pok_i,
  input  logic [NumBanks-1:0]           irq_en_i,
  input  logic [NumBanks-1:0]           irq_clr_i,
  output logic [NumPads-1:0][PokW-1:0]  pad_pok_o,
  output logic [NumBanks-1:0]           bank_ok_o,
  output logic [NumBanks-1:0]           change_o,
  output logic [NumBanks-1:0]           irq_status_o,
  output logic                          irq_o
);

  logic [NumBanks-1:0][PokW-1:0] st;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    pad_pok_debounce #(
      .PokW           (PokW),
      .DebounceCycles (DebounceCycles)
    ) u_deb (
      .clk    (clk),
      .rst_ni (rst_ni),
      .pok    (pok_i[b]),
      .st     (st[b]),
      .change (change_o[b])
    );
    assign bank_ok_o[b] = &st[b];
  end

  // Routing is fixed at elaboration time. A pad mapped to a bank that does not
  // exist reads all-zero.
  for (genvar p = 0; p < NumPads; p++) begin : g_pad
    if (int'(PadBank[p]) < int'(NumBanks)) begin : g_ok
      assign pad_pok_o[p] = st[PadBank[p]];
    end else begin : g_bad
      $error("pad_pok_monitor: PadBank entry selects a nonexistent bank");
      assign pad_pok_o[p] = '0;
    end
  end

  // The set is ORed in after the clear, so a change in the same cycle as a
  // clear leaves the status set.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      irq_status_o <= '0;
    end else begin
      irq_status_o <= (irq_status_o & ~irq_clr_i) | change_o;
    end
  end

  assign irq_o = |(irq_status_o & irq_en_i);

endmodule

// File: tb/tb_pad_pok_monitor.sv
// Directed bench for pad_pok_monitor: 4 banks, 8 pads, debounce of 4 cycles.
module tb_pad_pok_monitor;
  localparam int NB  = 4;
  localparam int NP  = 8;
  localparam int PW  = 8;
  localparam int DC  = 4;
  localparam int LAT = 2 + DC;
  localparam logic [NP-1:0][1:0] PB = {2'd3, 2'd3, 2'd2, 2'd2, 2'd1, 2'd1, 2'd0, 2'd0};

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  pad_pok_monitor_if #(.NumBanks(NB), .NumPads(NP), .PokW(PW)) bus ();

  pad_pok_monitor #(
    .NumBanks(NB), .NumPads(NP), .PokW(PW), .DebounceCycles(DC), .PadBank(PB)
  ) dut (
    .clk          (clk),
    .rst_ni       (rst_ni),
    .pok_i        (bus.pok_i),
    .irq_en_i     (bus.irq_en_i),
    .irq_clr_i    (bus.irq_clr_i),
    .pad_pok_o    (bus.pad_pok_o),
    .bank_ok_o    (bus.bank_ok_o),
    .change_o     (bus.change_o),
    .irq_status_o (bus.irq_status_o),
    .irq_o        (bus.irq_o)
  );

  typedef struct {
    string         tag;
    logic [NB-1:0] mask;
    int            lat;
  } exp_t;

  exp_t sb[$];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after driving. Edges are counted from the first posedge that
  // samples the new input. The task returns just after the edge where
  // change_o rises.
  task automatic expect_change();
    exp_t e;
    logic [NB-1:0] seen;
    int edges;
    seen  = '0;
    edges = -1;
    if (sb.size() == 0) begin
      check("scoreboard empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.change_o != '0) begin
        seen  = bus.change_o;
        edges = i;
        break;
      end
    end
    check({e.tag, " change mask"}, 64'(seen), 64'(e.mask));
    check({e.tag, " latency"}, 64'(edges), 64'(e.lat));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " pad_pok_o"}, bus.pad_pok_o, 64'd0);
    check({tag, " bank_ok_o"}, 64'(bus.bank_ok_o), 64'd0);
    check({tag, " change_o"}, 64'(bus.change_o), 64'd0);
    check({tag, " irq_status_o"}, 64'(bus.irq_status_o), 64'd0);
    check({tag, " irq_o"}, 64'(bus.irq_o), 64'd0);
  endtask

  initial begin
    int hits;
    bus.pok_i     = '0;
    bus.irq_en_i  = '0;
    bus.irq_clr_i = '0;
    repeat (2) @(negedge clk);
    bus.pok_i = {NB{8'hFF}};
    @(negedge clk); #1;
    check_all_zero("in reset");

    // Power-up: every bank becomes all-ones.
    @(negedge clk);
    rst_ni = 1'b1;
    sb.push_back('{"all_ff", 4'hF, LAT});
    expect_change();
    check("all_ff bank_ok_o", 64'(bus.bank_ok_o), 64'hF);
    check("all_ff pad_pok_o", bus.pad_pok_o, 64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    check("all_ff pulse width", 64'(bus.change_o), 64'd0);
    check("all_ff irq_status_o", 64'(bus.irq_status_o), 64'hF);
    check("all_ff irq_o masked", 64'(bus.irq_o), 64'd0);
    @(negedge clk); bus.irq_clr_i = 4'hF;
    @(negedge clk); bus.irq_clr_i = '0;
    check("clear all status", 64'(bus.irq_status_o), 64'd0);

    // A 3-cycle glitch on bank 1 must be rejected.
    @(negedge clk); bus.pok_i[1] = 8'h7F;
    repeat (3) @(negedge clk);
    bus.pok_i[1] = 8'hFF;
    hits = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (bus.change_o != '0) hits++;
    end
    check("glitch change pulses", 64'(hits), 64'd0);
    check("glitch pad_pok_o", bus.pad_pok_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check("glitch bank_ok_o", 64'(bus.bank_ok_o), 64'hF);

    // Distinct value on each bank; check the pad routing.
    @(negedge clk);
    bus.pok_i = {8'h44, 8'h33, 8'h22, 8'h11};
    sb.push_back('{"banks_4x", 4'hF, LAT});
    expect_change();
    check("routing pad_pok_o", bus.pad_pok_o, 64'h4444_3333_2222_1111);
    check("routing bank_ok_o", 64'(bus.bank_ok_o), 64'd0);
    repeat (2) @(negedge clk);
    bus.irq_clr_i = 4'hF;
    @(negedge clk); bus.irq_clr_i = '0;
    check("routing status cleared", 64'(bus.irq_status_o), 64'd0);

    // Clear in the same cycle as change_o[2]: the set must win.
    bus.irq_en_i = 4'b0100;
    @(negedge clk); bus.pok_i[2] = 8'h35;
    sb.push_back('{"bank2", 4'b0100, LAT});
    expect_change();
    bus.irq_clr_i = 4'b0100;
    @(posedge clk); #1;
    bus.irq_clr_i = '0;
    check("set wins irq_status_o", 64'(bus.irq_status_o), 64'b0100);
    check("set wins irq_o", 64'(bus.irq_o), 64'd1);
    @(negedge clk); bus.irq_clr_i = 4'b0100;
    @(negedge clk); bus.irq_clr_i = '0;
    check("lone clear irq_status_o", 64'(bus.irq_status_o), 64'd0);
    check("lone clear irq_o", 64'(bus.irq_o), 64'd0);

    // Reset in the middle of a bank 0 change, with the count at 2.
    @(negedge clk); bus.pok_i[0] = 8'h00;
    repeat (4) @(posedge clk);
    @(negedge clk); rst_ni = 1'b0;
    #1;
    check_all_zero("mid reset");
    @(negedge clk); rst_ni = 1'b1;
    // Bank 0 matches the reset value of st, so only banks 1..3 change.
    sb.push_back('{"after_rst", 4'b1110, LAT});
    expect_change();
    check("after_rst pad_pok_o", bus.pad_pok_o, 64'h4444_3535_2222_0000);
    check("after_rst bank_ok_o", 64'(bus.bank_ok_o), 64'd0);
    check("scoreboard drained", 64'(sb.size()), 64'd0);

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pad_pok_monitor.md
PAD_POK_MONITOR -- requirements
Module: pad_pok_monitor

Interface
REQ-001 The block SHALL have parameter NumBanks, default 4, giving the number of pad power banks.
REQ-002 The block SHALL have parameter NumPads, default 8, giving the number of pad channels routed from banks.
REQ-003 The block SHALL have parameter PokW, default 8, giving the width of one bank power-ok vector.
REQ-004 The block SHALL have parameter DebounceCycles, default 4, giving the consecutive cycles a new value must persist before it is accepted; legal range is 1..255.
REQ-005 The block SHALL have parameter PadBank, type logic [NumPads-1:0][BankIdxW-1:0], default '0, giving the bank index driving each pad.
REQ-006 The block SHALL have port clk, input, width 1: the single clock.
REQ-007 The block SHALL have port rst_ni, input, width 1: asynchronous active-low reset.
REQ-008 The block SHALL have port pok_i, input, [NumBanks-1:0][PokW-1:0]: raw bank power-ok vectors, asynchronous to clk.
REQ-009 The block SHALL have port irq_en_i, input, [NumBanks-1:0]: per-bank interrupt enable.
REQ-010 The block SHALL have port irq_clr_i, input, [NumBanks-1:0]: per-bank sticky-status clear pulse.
REQ-011 The block SHALL have port pad_pok_o, output, [NumPads-1:0][PokW-1:0]: debounced vector of the bank selected by PadBank per pad.
REQ-012 The block SHALL have port bank_ok_o, output, [NumBanks-1:0]: high when all PokW bits of the debounced bank vector are 1.
REQ-013 The block SHALL have port change_o, output, [NumBanks-1:0]: one-cycle pulse on each accepted bank change.
REQ-014 The block SHALL have port irq_status_o, output, [NumBanks-1:0]: sticky change status.
REQ-015 The block SHALL have port irq_o, output, width 1: OR of irq_status_o AND irq_en_i.

Function
REQ-016 Each pok_i bit SHALL pass a two-flop synchronizer; the synchronized bank value is s[b].
REQ-017 Each bank SHALL hold a stable register st[b] and a counter cnt[b] of width $clog2(DebounceCycles+1).
REQ-018 When s[b] == st[b], cnt[b] SHALL be 0.
REQ-019 When s[b] differs from its previous-cycle value, cnt[b] SHALL reload to 0.
REQ-020 When s[b] != st[b] and s[b] is unchanged, cnt[b] SHALL increment; at cnt[b] == DebounceCycles-1, the next edge SHALL load st[b] <= s[b], clear cnt[b] and assert change_o[b] for exactly that one cycle.
REQ-021 A pok_i change held steady SHALL appear on st, pad_pok_o and bank_ok_o exactly 2+DebounceCycles clock edges after the first edge that samples it.
REQ-022 A glitch shorter than DebounceCycles synchronized cycles SHALL never change st.
REQ-023 When DebounceCycles == 1, the first cycle of difference SHALL commit.
REQ-024 pad_pok_o[p] SHALL equal st[PadBank[p]] combinationally from registers.
REQ-025 If PadBank[p] >= NumBanks, pad_pok_o[p] SHALL be '0 and an elaboration assertion SHALL fire.
REQ-026 irq_status_o[b] SHALL set on change_o[b] and clear on irq_clr_i[b]; when both occur in the same cycle, set SHALL win.
REQ-027 irq_o SHALL be registered-logic-free (combinational from irq_status_o and irq_en_i).
REQ-028 Banks SHALL operate fully independently; simultaneous changes on several banks SHALL each produce their own pulse.

Reset
REQ-029 While rst_ni is low, synchronizers, st, cnt, change_o, irq_status_o SHALL be 0, so pad_pok_o = '0, bank_ok_o = 0 and irq_o = 0.
REQ-030 A reset asserted mid-debounce SHALL discard the pending count; after release, acceptance SHALL restart from cnt = 0.

Structure
REQ-031 pad_pok_t and the bank-index type SHALL live in the shared package prim_pad_wrapper_pkg, generalized by PokW; BankIdxW = max(1, $clog2(NumBanks)) SHALL be derived locally.
REQ-032 Per-bank synchronizer plus debounce SHALL be the sub-module pad_pok_debounce, instantiated NumBanks times.

Verification
REQ-033 Reset, pok_i = all 0xFF, DebounceCycles = 4 -> bank_ok_o = 4'hF, change_o pulses once per bank, 6 edges after first sample.
REQ-034 Bank 1 glitch 0xFF->0x7F for 3 cycles -> no change_o[1], st[1] stays 0xFF.
REQ-035 PadBank = {3,3,2,2,1,1,0,0}, banks 0x11/0x22/0x33/0x44 -> pad_pok_o[7:0] = 44,44,33,33,22,22,11,11.
REQ-036 change_o[2] and irq_clr_i[2] in the same cycle, irq_en_i[2] = 1 -> irq_status_o[2] = 1, irq_o = 1; later lone clear -> 0.
REQ-037 rst_ni asserted at cnt = 2 mid-change -> all outputs 0 immediately; after release, full 2+DebounceCycles latency is required again.
